ps2_key_event_scheduler: RTL and testbench
==========================================

Name: ps2_key_event_scheduler

Overview:
- Sits between the PS/2 byte receiver and the game-logic consumers.
- Sequences the raw scan-code byte stream into discrete press/release events, including break (F0) and extended (E0) prefix handling.
- Suppresses typematic auto-repeat using a small held-key table.
- Buffers events in a FIFO that consumers drain with a valid/ready handshake. Replaces level-style "last key" sampling with exactly-once key events.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- HELD_SLOTS, 4, number of simultaneously tracked held keys for repeat suppression.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- byte_valid  input  1  one-cycle strobe: a new scan-code byte is on byte_in.
- byte_in  input  8  raw PS/2 scan-code byte.
- event_ready  input  1  consumer accepts the head event this cycle.
- event_valid  output  1  FIFO head holds a valid event.
- event_code  output  8  scan code of the head event (prefixes stripped).
- event_ext  output  1  head event was E0-prefixed.
- event_release  output  1  1 = key release, 0 = key press.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- held_count  output  3  number of occupied held-table slots.

Behaviour:
- Reset: on the clock edge with reset=1, all state clears: FSM goes to IDLE, held table is emptied, FIFO is emptied. event_valid=0, event_code=0, event_ext=0, event_release=0, overflow=0, held_count=0. Reset overrides any same-cycle byte_valid or pop, including mid-prefix.
- Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. It advances only on byte_valid.
  - IDLE: E0 -> GOT_E0. F0 -> GOT_F0. E1, AA, FA, FE, EE are dropped and the FSM stays in IDLE. Any other byte is a make code (ext=0), then IDLE.
  - GOT_E0: F0 -> GOT_E0F0. E0 stays in GOT_E0. Any other byte is a make code (ext=1), then IDLE.
  - GOT_F0: any byte other than E0/F0 is a break code (ext=0), then IDLE. E0 -> GOT_E0F0. F0 stays in GOT_F0.
  - GOT_E0F0: any byte other than E0/F0 is a break code (ext=1), then IDLE. E0/F0 stay in GOT_E0F0.
- Make handling (key {ext, code}):
  - Key already in held table: repeat; no event.
  - Otherwise: insert into the lowest free slot and emit a press event.
  - Table full: still emit the press event; the key is not tracked, so its repeats each emit a press.
- Break handling: clear the matching slot if present, and always emit a release event.
- Table update and FIFO push occur on the same edge that samples byte_valid.
- Latency: byte_valid in cycle N with an empty FIFO gives event_valid=1 in cycle N+1, with event fields stable while event_valid=1 and event_ready=0.
- Handshake: pop when event_valid & event_ready. event_ready with an empty FIFO has no effect.
- FIFO full:
  - Push with no pop: the event is dropped, overflow is set and held until reset. The held-table update still happens.
  - Push and pop in the same cycle: both are performed and occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- Outputs are driven from registers or the FIFO head. There is no combinational path from byte_in to the outputs.

Decomposition:
- Shared package ps2_event_pkg holds:
  - Byte constants: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_PAUSE=8'hE1, SC_BAT=8'hAA, SC_ACK=8'hFA, SC_RESEND=8'hFE, SC_ECHO=8'hEE.
  - FSM state encoding.
  - 10-bit event word layout {release, ext, code[7:0]}.
- Sub-module ps2_event_fifo: synchronous FIFO parameterised by depth and width 10, with push/pop/full/empty/count. It is reusable by other keyboard consumers.

Test Plan:
- Press/release: bytes 1D, F0, 1D (one per 4 cycles, empty FIFO, ready=1) -> events {press, ext0, 1D} then {release, ext0, 1D}. held_count goes 1 then 0. Each event_valid appears the cycle after its final byte.
- Typematic: 1D, 1D, 1D, F0, 1D -> exactly 2 events (press 1D, release 1D), no duplicates.
- Extended key: E0, 75, E0, F0, 75 -> {press, ext1, 75} then {release, ext1, 75}. Non-extended 75 pressed while E0-75 is held -> separate press, held_count=2.
- Overflow: ready=0, six distinct make codes 15, 1D, 24, 2D, 2C, 35 with FIFO_DEPTH=4 and HELD_SLOTS=4 -> first four events queued, overflow=1. Then draining with ready=1 yields 15, 1D, 24, 2D. Table full: repeated 2C emits a press each time.
- Simultaneous push/pop at full: FIFO full, ready=1 and byte_valid=16 in the same cycle -> count stays 4, no overflow, 16 appears last in order.
- Reset mid-prefix: E0, F0, reset pulse, then 1D -> {press, ext0, 1D}. All outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/ps2_event_pkg.sv
// Shared definitions for the PS/2 key event path: scan-code constants,
// prefix FSM encoding and the 10-bit event word layout.
package ps2_event_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;

  localparam int EVENT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } prefix_state_t;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } event_word_t;

  // Keyboard status/control bytes that never describe a key when seen unprefixed.
  function automatic logic is_ignored_byte(input logic [7:0] b);
    return (b == SC_PAUSE) || (b == SC_BAT) || (b == SC_ACK) ||
           (b == SC_RESEND) || (b == SC_ECHO);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO with head-of-queue visibility, usable by any keyboard
// consumer. Push is accepted when full only if a pop happens on the same edge.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_scheduler.sv
// Turns the raw PS/2 scan-code byte stream into exactly-once press/release
// events, suppressing typematic repeats, and queues them for a consumer.
module ps2_key_event_scheduler
  import ps2_event_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HELD_SLOTS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_release,
  output logic       overflow,
  output logic [2:0] held_count
);

  prefix_state_t r_state;

  logic       w_key_event;
  logic       w_is_break;
  logic       w_is_ext;
  logic [8:0] w_key;
  logic       w_make;
  logic       w_break;
  logic       w_insert;
  logic       w_push;

  always_comb begin
    w_key_event = 1'b0;
    w_is_break  = 1'b0;
    w_is_ext    = 1'b0;
    if (byte_valid && (byte_in != SC_EXT) && (byte_in != SC_BREAK)) begin
      case (r_state)
        ST_IDLE:     w_key_event = ~is_ignored_byte(byte_in);
        ST_GOT_E0:   begin w_key_event = 1'b1; w_is_ext = 1'b1; end
        ST_GOT_F0:   begin w_key_event = 1'b1; w_is_break = 1'b1; end
        ST_GOT_E0F0: begin w_key_event = 1'b1; w_is_ext = 1'b1; w_is_break = 1'b1; end
        default:     w_key_event = 1'b0;
      endcase
    end
  end

  assign w_key   = {w_is_ext, byte_in};
  assign w_make  = w_key_event & ~w_is_break;
  assign w_break = w_key_event & w_is_break;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (byte_in == SC_EXT)        r_state <= ST_GOT_E0;
          else if (byte_in == SC_BREAK) r_state <= ST_GOT_F0;
          else                          r_state <= ST_IDLE;
        end
        ST_GOT_E0: begin
          if (byte_in == SC_BREAK)      r_state <= ST_GOT_E0F0;
          else if (byte_in == SC_EXT)   r_state <= ST_GOT_E0;
          else                          r_state <= ST_IDLE;
        end
        ST_GOT_F0: begin
          if (byte_in == SC_EXT)        r_state <= ST_GOT_E0F0;
          else if (byte_in == SC_BREAK) r_state <= ST_GOT_F0;
          else                          r_state <= ST_IDLE;
        end
        ST_GOT_E0F0: begin
          if ((byte_in == SC_EXT) || (byte_in == SC_BREAK)) r_state <= ST_GOT_E0F0;
          else                                              r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Held-key table: a make of a tracked key is a typematic repeat.
  logic [HELD_SLOTS-1:0] r_slot_valid;
  logic [8:0]            r_slot_key [HELD_SLOTS];
  logic [HELD_SLOTS-1:0] w_hit;
  logic [HELD_SLOTS-1:0] w_ins_onehot;
  logic [HELD_SLOTS-1:0] w_slot_valid_next;
  logic [HELD_SLOTS:0]   w_free_below;
  logic [2:0]            w_held_next;
  logic [2:0]            r_held_count;

  assign w_free_below[0] = 1'b0;

  for (genvar gi = 0; gi < HELD_SLOTS; gi++) begin : g_slot
    assign w_hit[gi]             = r_slot_valid[gi] && (r_slot_key[gi] == w_key);
    assign w_ins_onehot[gi]      = ~r_slot_valid[gi] & ~w_free_below[gi];
    assign w_free_below[gi+1]    = w_free_below[gi] | ~r_slot_valid[gi];
    assign w_slot_valid_next[gi] = (r_slot_valid[gi] | (w_insert & w_ins_onehot[gi]))
                                   & ~(w_break & w_hit[gi]);
  end

  // A full table leaves w_ins_onehot zero, so the press is emitted untracked.
  assign w_insert = w_make & ~(|w_hit);
  assign w_push   = w_insert | w_break;

  always_comb begin
    w_held_next = '0;
    for (int i = 0; i < HELD_SLOTS; i++) begin
      w_held_next = w_held_next + {2'b00, w_slot_valid_next[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_slot_valid <= '0;
      r_held_count <= '0;
      for (int i = 0; i < HELD_SLOTS; i++) r_slot_key[i] <= '0;
    end else begin
      r_slot_valid <= w_slot_valid_next;
      r_held_count <= w_held_next;
      for (int i = 0; i < HELD_SLOTS; i++) begin
        if (w_insert && w_ins_onehot[i]) r_slot_key[i] <= w_key;
      end
    end
  end

  event_word_t                 w_push_word;
  event_word_t                 w_head;
  logic [EVENT_W-1:0]          w_head_bits;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                        w_pop;
  logic                        r_overflow;

  assign w_push_word = '{rel: w_is_break, ext: w_is_ext, code: byte_in};
  assign w_head      = event_word_t'(w_head_bits);
  assign w_pop       = event_ready & (w_fifo_count != '0);

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_head  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Head fields are masked while empty so stale storage never shows.
  assign event_valid   = ~w_empty;
  assign event_code    = w_empty ? 8'h00 : w_head.code;
  assign event_ext     = ~w_empty & w_head.ext;
  assign event_release = ~w_empty & w_head.rel;
  assign overflow      = r_overflow;
  assign held_count    = r_held_count;

endmodule

// File: tb/tb_ps2_key_event_scheduler.sv
// Directed bench for ps2_key_event_scheduler: prefix decoding, repeat
// suppression, FIFO overflow, push/pop at full and reset mid-prefix.
module tb_ps2_key_event_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       event_ready;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_release;
  logic       overflow;
  logic [2:0] held_count;

  int errors = 0;
  int checks = 0;

  ps2_key_event_scheduler #(
    .FIFO_DEPTH (4),
    .HELD_SLOTS (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .byte_valid    (byte_valid),
    .byte_in       (byte_in),
    .event_ready   (event_ready),
    .event_valid   (event_valid),
    .event_code    (event_code),
    .event_ext     (event_ext),
    .event_release (event_release),
    .overflow      (overflow),
    .held_count    (held_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    $display("byte %02h -> valid=%0b code=%02h ext=%0b rel=%0b held=%0d ovf=%0b",
             b, event_valid, event_code, event_ext, event_release, held_count, overflow);
  endtask

  task automatic pop();
    $display("pop  code=%02h ext=%0b rel=%0b", event_code, event_ext, event_release);
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [7:0] code,
                             input logic ext, input logic rel);
    check({tag, ".valid"}, event_valid, 1);
    check({tag, ".code"},  event_code, code);
    check({tag, ".ext"},   event_ext, ext);
    check({tag, ".rel"},   event_release, rel);
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, ".valid"}, event_valid, 0);
    check({tag, ".code"},  event_code, 0);
    check({tag, ".ext"},   event_ext, 0);
    check({tag, ".rel"},   event_release, 0);
    check({tag, ".ovf"},   overflow, 0);
    check({tag, ".held"},  held_count, 0);
  endtask

  initial begin
    reset       = 1'b1;
    byte_valid  = 1'b0;
    byte_in     = 8'h00;
    event_ready = 1'b0;
    idle(2);
    reset = 1'b0;
    expect_quiet("reset");

    // Press/release with a consumer that is always ready
    event_ready = 1'b1;
    send(8'h1D);
    expect_head("pr.press", 8'h1D, 1'b0, 1'b0);
    check("pr.held1", held_count, 1);
    idle(3);
    check("pr.drained1", event_valid, 0);
    send(8'hF0);
    check("pr.prefix_quiet", event_valid, 0);
    idle(3);
    send(8'h1D);
    expect_head("pr.release", 8'h1D, 1'b0, 1'b1);
    check("pr.held0", held_count, 0);
    idle(3);
    check("pr.drained2", event_valid, 0);
    event_ready = 1'b0;

    // Typematic repeats collapse to one press
    send(8'h1D);
    send(8'h1D);
    send(8'h1D);
    check("tm.held", held_count, 1);
    send(8'hF0);
    send(8'h1D);
    check("tm.held0", held_count, 0);
    expect_head("tm.ev0", 8'h1D, 1'b0, 1'b0);
    pop();
    expect_head("tm.ev1", 8'h1D, 1'b0, 1'b1);
    pop();
    check("tm.empty", event_valid, 0);

    // Extended key alongside its non-extended twin
    send(8'hE0);
    send(8'h75);
    check("ex.held1", held_count, 1);
    send(8'h75);
    check("ex.held2", held_count, 2);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("ex.held_after_e0rel", held_count, 1);
    send(8'hF0);
    send(8'h75);
    check("ex.held0", held_count, 0);
    check("ex.ovf", overflow, 0);
    expect_head("ex.ev0", 8'h75, 1'b1, 1'b0);
    pop();
    expect_head("ex.ev1", 8'h75, 1'b0, 1'b0);
    pop();
    expect_head("ex.ev2", 8'h75, 1'b1, 1'b1);
    pop();
    expect_head("ex.ev3", 8'h75, 1'b0, 1'b1);
    pop();
    check("ex.empty", event_valid, 0);

    // Overflow: six makes into a four-entry FIFO and four-slot table
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    check("of.ovf_before", overflow, 0);
    send(8'h2C);
    send(8'h35);
    check("of.ovf", overflow, 1);
    check("of.held", held_count, 4);
    expect_head("of.ev0", 8'h15, 1'b0, 1'b0);
    pop();
    expect_head("of.ev1", 8'h1D, 1'b0, 1'b0);
    pop();
    expect_head("of.ev2", 8'h24, 1'b0, 1'b0);
    pop();
    expect_head("of.ev3", 8'h2D, 1'b0, 1'b0);
    pop();
    check("of.empty", event_valid, 0);
    check("of.ovf_sticky", overflow, 1);
    send(8'h2C);
    expect_head("of.untracked1", 8'h2C, 1'b0, 1'b0);
    pop();
    send(8'h2C);
    expect_head("of.untracked2", 8'h2C, 1'b0, 1'b0);
    pop();
    check("of.empty2", event_valid, 0);
    check("of.held_full", held_count, 4);

    // Simultaneous push and pop while full
    pulse_reset();
    expect_quiet("pp.reset");
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    event_ready = 1'b1;
    send(8'h16);
    event_ready = 1'b0;
    check("pp.ovf", overflow, 0);
    check("pp.held", held_count, 4);
    expect_head("pp.ev0", 8'h1D, 1'b0, 1'b0);
    pop();
    expect_head("pp.ev1", 8'h24, 1'b0, 1'b0);
    pop();
    expect_head("pp.ev2", 8'h2D, 1'b0, 1'b0);
    pop();
    expect_head("pp.ev3", 8'h16, 1'b0, 1'b0);
    pop();
    check("pp.empty", event_valid, 0);

    // Reset in the middle of an E0 F0 prefix
    send(8'hE0);
    send(8'hF0);
    pulse_reset();
    expect_quiet("rm.reset");
    send(8'h1D);
    expect_head("rm.ev", 8'h1D, 1'b0, 1'b0);
    check("rm.held", held_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
